// File: rtl/alu_pkg.sv
// Shared opcode and FSM state types for alu_seq.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_NOT = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SLT = 4'd6,
    OP_EQ  = 4'd7,
    OP_MUL = 4'd8,
    OP_SLL = 4'd9,
    OP_SRL = 4'd10,
    OP_SRA = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] OP_ILLEGAL_MIN = 4'd12;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier; one partial product per cycle, WIDTH cycles.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [SHW-1:0]     r_cnt;
  logic               r_busy;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (start) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (r_cnt == SHW'(WIDTH - 1)) r_busy <= 1'b0;
    end
  end

  // Final product is exposed combinationally during the last step so the
  // caller can register it on the same edge the step completes.
  assign busy = r_busy;
  assign done = r_busy && (r_cnt == SHW'(WIDTH - 1));
  assign prod = w_acc_next;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes; ALU_SEQ_MUL_EN enables the iterative multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             car,
  output logic             of,
  output logic             zf,
  output logic             err
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_res;
  logic             r_car, r_of, r_zf, r_err;

  logic             w_accept, w_load;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res, w_ld_res;
  logic             w_car, w_of, w_err;
  logic             w_ld_car, w_ld_of, w_ld_err;

`ifdef ALU_SEQ_MUL_EN
  logic               w_is_mul, w_mul_start, w_mul_busy, w_mul_done;
  logic [2*WIDTH-1:0] w_mul_prod;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (w_mul_start),
    .a     (a),
    .b     (b),
    .busy  (w_mul_busy),
    .done  (w_mul_done),
    .prod  (w_mul_prod)
  );
`endif

  assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == DONE);
  assign res       = r_res;
  assign car       = r_car;
  assign of        = r_of;
  assign zf        = r_zf;
  assign err       = r_err;

  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_car = 1'b0;
    w_of  = 1'b0;
    w_err = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    w_is_mul = 1'b0;
`endif
    case (op_e'(op))
      OP_ADD: begin
        w_sum = {1'b0, a} + {1'b0, b};
        w_res = w_sum[WIDTH-1:0];
        w_car = w_sum[WIDTH];
        w_of  = (a[WIDTH-1] == b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        w_res = w_sum[WIDTH-1:0];
        w_car = w_sum[WIDTH];
        w_of  = (a[WIDTH-1] != b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NOT: w_res = ~a;
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_SLT: w_res[0] = ($signed(a) < $signed(b));
      OP_EQ:  w_res[0] = (a == b);
      OP_SLL: w_res = a << b[SHW-1:0];
      OP_SRL: w_res = a >> b[SHW-1:0];
      OP_SRA: w_res = $unsigned($signed(a) >>> b[SHW-1:0]);
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: w_is_mul = 1'b1;
`endif
      default: w_err = 1'b1;
    endcase
  end

  always_comb begin
    w_ld_res = w_res;
    w_ld_car = w_car;
    w_ld_of  = w_of;
    w_ld_err = w_err;
`ifdef ALU_SEQ_MUL_EN
    if (r_state == MUL) begin
      w_ld_res = w_mul_prod[WIDTH-1:0];
      w_ld_car = 1'b0;
      w_ld_of  = |w_mul_prod[2*WIDTH-1:WIDTH];
      w_ld_err = 1'b0;
    end
`endif
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    w_mul_start  = 1'b0;
`endif
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
`ifdef ALU_SEQ_MUL_EN
          if (w_is_mul) begin
            w_mul_start  = 1'b1;
            w_state_next = MUL;
          end else
`endif
          begin
            w_load       = 1'b1;
            w_state_next = DONE;
          end
        end else if ((r_state == DONE) && out_ready) begin
          w_state_next = IDLE;
        end
      end
      MUL: begin
`ifdef ALU_SEQ_MUL_EN
        if (w_mul_done) begin
          w_load       = 1'b1;
          w_state_next = DONE;
        end else if (!w_mul_busy) begin
          w_state_next = IDLE;
        end
`else
        w_state_next = IDLE;
`endif
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_res   <= '0;
      r_car   <= 1'b0;
      r_of    <= 1'b0;
      r_zf    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_res <= w_ld_res;
        r_car <= w_ld_car;
        r_of  <= w_ld_of;
        r_zf  <= (w_ld_res == '0);
        r_err <= w_ld_err;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8); expectations follow ALU_SEQ_MUL_EN if defined.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [3:0] op = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] res;
  logic       car, of, zf, err;

  typedef struct {
    string      name;
    logic [7:0] res;
    logic       car, of, zf, err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .car       (car),
    .of        (of),
    .zf        (zf),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one pop per completed output handshake.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_output", {res, car, of, zf, err}, 32'hDEAD);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk(e.name, {res, car, of, zf, err}, {e.res, e.car, e.of, e.zf, e.err});
      end
    end
  end

  // Drives one op until accepted; returns at accept edge + 1.
  task automatic send(input string name, input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb,
                      input logic [7:0] r, input logic c, input logic v, input logic z, input logic e,
                      input bit push);
    int n;
    if (push) q.push_back('{name, r, c, v, z, e});
    op = o; a = xa; b = xb; in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk({name, "_accept_timeout"}, 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'h00; b = 8'h00; op = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  bad;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_outs", {out_valid, in_ready, res, car, of, zf, err}, {1'b0, 1'b1, 8'h00, 4'b0000});

    send("add_of", 4'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("add_latency", out_valid, 1'b1);
    send("sub_borrow",  4'd1,  8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send("sub_of",      4'd1,  8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    send("sub_zero",    4'd1,  8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    send("add_carry",   4'd0,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    send("not",         4'd2,  8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send("and",         4'd3,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send("or",          4'd4,  8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send("xor",         4'd5,  8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send("slt",         4'd6,  8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send("slt_false",   4'd6,  8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send("eq",          4'd7,  8'h5A, 8'h5A, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send("eq_false",    4'd7,  8'h5A, 8'h5B, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send("sll",         4'd9,  8'h81, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send("srl",         4'd10, 8'h81, 8'h04, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send("sra",         4'd11, 8'h80, 8'h03, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send("sra_amt_mask",4'd11, 8'h40, 8'hF9, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send("illegal13",   4'd13, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("illegal_latency", out_valid, 1'b1);

`ifdef ALU_SEQ_MUL_EN
    send("mul", 4'd8, 8'h10, 8'h11, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
`else
    send("mul_disabled", 4'd8, 8'h10, 8'h11, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
`endif
    n = 0; bad = 1'b0;
    while (!out_valid && n < 40) begin
      if (in_ready) bad = 1'b1;
      @(posedge clk); #1; n++;
    end
`ifdef ALU_SEQ_MUL_EN
    chk("mul_latency", n, 8);
`else
    chk("mul_disabled_latency", n, 0);
`endif
    chk("mul_in_ready_low", bad, 1'b0);

    repeat (2) @(posedge clk); #1;
    out_ready = 1'b0;
    send("stall_add", 4'd0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if ({out_valid, in_ready, res, car, of, zf, err} !== {1'b1, 1'b0, 8'h03, 4'b0000}) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("stall_stable", bad, 1'b0);

    q.push_back('{"b2b_xor", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0});
    out_ready = 1'b1;
    op = 4'd5; a = 8'hAA; b = 8'h55; in_valid = 1'b1;
    #1;
    chk("b2b_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_no_bubble", {out_valid, res}, {1'b1, 8'hFF});

    repeat (2) @(posedge clk); #1;
    out_ready = 1'b0;
    send("abort_done", 4'd0, 8'h7F, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    chk("abort_done_outs", {out_valid, in_ready, res, car, of, zf, err}, {1'b0, 1'b1, 8'h00, 4'b0000});

`ifdef ALU_SEQ_MUL_EN
    send("abort_mul", 4'd8, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_mul_outs", {out_valid, in_ready, res, car, of, zf, err}, {1'b0, 1'b1, 8'h00, 4'b0000});
`endif
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("no_stale_result", bad, 1'b0);

    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
